// File: rtl/uart_rx_deframer.sv
// UART receive deframer: assembles start/data/parity/stop bits from the sampler
// into a parallel word with parity and framing error flags.
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  sampler_stop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  sampler_stop_q, sampler_stop_d;
  logic                  busy_q, busy_d;

  // Next-state and output computation; outputs are loaded on the edge entering DONE.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    par_bit_d      = par_bit_q;
    ferr_d         = ferr_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_err_d   = parity_err_q;
    frame_err_d    = frame_err_q;
    sampler_stop_d = 1'b0;
    busy_d         = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bit_valid) begin
          if (!bit_in) begin
            state_d = S_DATA;
            cnt_d   = '0;
            ferr_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d        = S_DONE;
            sampler_stop_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (bit_valid) begin
          shift_d = {bit_in, shift_q[DATA_WIDTH-1:1]};
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_valid) begin
          par_bit_d = bit_in;
          state_d   = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_valid) begin
          ferr_d = ferr_q | ~bit_in;
          if (cnt_q == LAST_STOP) begin
            state_d        = S_DONE;
            sampler_stop_d = 1'b1;
            data_valid_d   = 1'b1;
            data_out_d     = shift_q;
            frame_err_d    = ferr_d;
            parity_err_d   = PAR_EN & (par_bit_q != expected_parity(shift_q, PAR_ODD));
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      par_bit_q      <= 1'b0;
      ferr_q         <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      sampler_stop_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      par_bit_q      <= par_bit_d;
      ferr_q         <= ferr_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_err_q   <= parity_err_d;
      frame_err_q    <= frame_err_d;
      sampler_stop_q <= sampler_stop_d;
      busy_q         <= busy_d;
    end
  end

  assign sampler_stop = sampler_stop_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: four instances (8N1, 8E1, 8O1, 8N2) driven from a
// vector table, hand-written reset sequence and randomized frames against a frame-level model.
module tb_uart_rx_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       bin[4];
  logic       bval[4];
  logic       ss[4];
  logic       dv[4];
  logic       perr[4];
  logic       ferr[4];
  logic       busy[4];
  logic [7:0] dout[4];

  int cfg_par[4]  = '{0, 1, 1, 0};
  int cfg_odd[4]  = '{0, 0, 1, 0};
  int cfg_stop[4] = '{1, 1, 1, 2};

  uart_rx_deframer #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .bit_in(bin[0]), .bit_valid(bval[0]), .sampler_stop(ss[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .busy(busy[0]));
  uart_rx_deframer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .bit_in(bin[1]), .bit_valid(bval[1]), .sampler_stop(ss[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .busy(busy[1]));
  uart_rx_deframer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .bit_in(bin[2]), .bit_valid(bval[2]), .sampler_stop(ss[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .busy(busy[2]));
  uart_rx_deframer #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .bit_in(bin[3]), .bit_valid(bval[3]), .sampler_stop(ss[3]),
    .data_out(dout[3]), .data_valid(dv[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .busy(busy[3]));

  int         n_checks = 0;
  int         n_pass   = 0;
  int         dv_cnt[4]     = '{0, 0, 0, 0};
  int         exp_dv_cnt[4] = '{0, 0, 0, 0};
  logic [7:0] last_dout[4];
  logic       last_perr[4];
  logic       last_ferr[4];

  typedef struct {
    int         d;
    logic       start;
    logic [7:0] data;
    logic       pb;
    logic [1:0] stops;
    logic       exp_dv;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[11];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dv[i] === 1'b1) dv_cnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic send_bit(input int d, input logic b);
    repeat (2) @(negedge clk);
    bin[d]  = b;
    bval[d] = 1'b1;
    @(negedge clk);
    bval[d] = 1'b0;
  endtask

  task automatic check_zero(input int d, input string tag);
    chk($sformatf("%s_dout%0d", tag, d), {24'd0, dout[d]}, 32'd0);
    chk($sformatf("%s_dv%0d", tag, d), {31'd0, dv[d]}, 32'd0);
    chk($sformatf("%s_ss%0d", tag, d), {31'd0, ss[d]}, 32'd0);
    chk($sformatf("%s_perr%0d", tag, d), {31'd0, perr[d]}, 32'd0);
    chk($sformatf("%s_ferr%0d", tag, d), {31'd0, ferr[d]}, 32'd0);
    chk($sformatf("%s_busy%0d", tag, d), {31'd0, busy[d]}, 32'd0);
  endtask

  task automatic run_frame(input int d, input logic start, input logic [7:0] data, input logic pb,
                           input logic [1:0] stops, input logic exp_dv, input logic [7:0] exp_dout,
                           input logic exp_perr, input logic exp_ferr);
    send_bit(d, start);
    if (!start) begin
      chk($sformatf("busy_after_start%0d", d), {31'd0, busy[d]}, 32'd1);
      for (int i = 0; i < 8; i++) send_bit(d, data[i]);
      if (cfg_par[d] != 0) send_bit(d, pb);
      for (int i = 0; i < cfg_stop[d]; i++) send_bit(d, stops[i]);
    end
    // One cycle after the final bit_valid: the DONE cycle.
    chk($sformatf("sampler_stop%0d", d), {31'd0, ss[d]}, 32'd1);
    chk($sformatf("data_valid%0d", d), {31'd0, dv[d]}, {31'd0, exp_dv});
    chk($sformatf("busy_done%0d", d), {31'd0, busy[d]}, {31'd0, ~start});
    if (exp_dv) begin
      chk($sformatf("data_out%0d", d), {24'd0, dout[d]}, {24'd0, exp_dout});
      chk($sformatf("parity_err%0d", d), {31'd0, perr[d]}, {31'd0, exp_perr});
      chk($sformatf("frame_err%0d", d), {31'd0, ferr[d]}, {31'd0, exp_ferr});
      last_dout[d] = exp_dout;
      last_perr[d] = exp_perr;
      last_ferr[d] = exp_ferr;
      exp_dv_cnt[d]++;
    end else begin
      chk($sformatf("hold_dout_fs%0d", d), {24'd0, dout[d]}, {24'd0, last_dout[d]});
    end
    @(negedge clk);
    chk($sformatf("sampler_stop_end%0d", d), {31'd0, ss[d]}, 32'd0);
    chk($sformatf("data_valid_end%0d", d), {31'd0, dv[d]}, 32'd0);
    chk($sformatf("busy_end%0d", d), {31'd0, busy[d]}, 32'd0);
    chk($sformatf("hold_dout%0d", d), {24'd0, dout[d]}, {24'd0, last_dout[d]});
    chk($sformatf("hold_perr%0d", d), {31'd0, perr[d]}, {31'd0, last_perr[d]});
    chk($sformatf("hold_ferr%0d", d), {31'd0, ferr[d]}, {31'd0, last_ferr[d]});
  endtask

  initial begin
    logic [7:0] rdata;
    logic       rstart, rpb, rexp_perr, rexp_ferr;
    logic [1:0] rstops;
    int         rd;

    for (int i = 0; i < 4; i++) begin
      bin[i] = 1'b1; bval[i] = 1'b0;
      last_dout[i] = 8'h00; last_perr[i] = 1'b0; last_ferr[i] = 1'b0;
    end

    //                d  start  data   pb    stops  dv    dout   perr  ferr
    tbl[0]  = '{0, 1'b0, 8'hA5, 1'b0, 2'b11, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1]  = '{1, 1'b0, 8'h0F, 1'b1, 2'b11, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[2]  = '{1, 1'b0, 8'h0F, 1'b0, 2'b11, 1'b1, 8'h0F, 1'b0, 1'b0};
    tbl[3]  = '{2, 1'b0, 8'h0F, 1'b1, 2'b11, 1'b1, 8'h0F, 1'b0, 1'b0};
    tbl[4]  = '{0, 1'b0, 8'h55, 1'b0, 2'b10, 1'b1, 8'h55, 1'b0, 1'b1};
    tbl[5]  = '{0, 1'b0, 8'h55, 1'b0, 2'b11, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[6]  = '{0, 1'b1, 8'h00, 1'b0, 2'b11, 1'b0, 8'h55, 1'b0, 1'b0};
    tbl[7]  = '{0, 1'b0, 8'h3C, 1'b0, 2'b11, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[8]  = '{1, 1'b0, 8'h80, 1'b0, 2'b10, 1'b1, 8'h80, 1'b1, 1'b1};
    tbl[9]  = '{3, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{3, 1'b0, 8'hFF, 1'b0, 2'b11, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check_zero(i, "reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].d, tbl[i].start, tbl[i].data, tbl[i].pb, tbl[i].stops,
                tbl[i].exp_dv, tbl[i].exp_dout, tbl[i].exp_perr, tbl[i].exp_ferr);

    // Reset after 4 data bits: partial word must vanish.
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    chk("busy_midframe", {31'd0, busy[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero(0, "midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      last_dout[i] = 8'h00; last_perr[i] = 1'b0; last_ferr[i] = 1'b0;
    end
    run_frame(0, 1'b0, 8'h3C, 1'b0, 2'b11, 1'b1, 8'h3C, 1'b0, 1'b0);

    for (int i = 8; i < 11; i++)
      run_frame(tbl[i].d, tbl[i].start, tbl[i].data, tbl[i].pb, tbl[i].stops,
                tbl[i].exp_dv, tbl[i].exp_dout, tbl[i].exp_perr, tbl[i].exp_ferr);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 40; n++) begin
      rd     = int'($urandom_range(0, 3));
      rdata  = 8'($urandom);
      rstart = ($urandom_range(0, 7) == 0);
      rpb    = 1'($urandom);
      rstops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      rexp_perr = (cfg_par[rd] != 0) ? (rpb != ((^rdata) ^ (cfg_odd[rd] != 0))) : 1'b0;
      rexp_ferr = !rstops[0] || (cfg_stop[rd] == 2 && !rstops[1]);
      run_frame(rd, rstart, rdata, rpb, rstops, !rstart, rdata, rexp_perr, rexp_ferr);
    end

    for (int i = 0; i < 4; i++)
      chk($sformatf("dv_count%0d", i), dv_cnt[i], exp_dv_cnt[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
